// File: rtl/replacer_pkg.sv
// Shared types and helpers for the replacer expansion path: arbiter state
// encoding, default data width and the round-robin lane search.
package replacer_pkg;

    localparam int DEF_DW    = 8;
    localparam int MAX_LANES = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    // First requesting lane strictly after 'last' in circular order; returns
    // 'last' itself when nothing is requesting. Scanning from the far end lets
    // the nearest requester overwrite the farther ones.
    function automatic logic [2:0] rr_next(input logic [MAX_LANES-1:0] req,
                                           input logic [2:0]           last,
                                           input int                   lanes);
        logic [2:0] sel;
        int         idx;
        sel = last;
        for (int i = MAX_LANES; i >= 1; i--) begin
            if (i <= lanes) begin
                idx = (int'(last) + i) % lanes;
                if (req[idx]) sel = 3'(idx);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/extend_lane_arbiter.sv
// Round-robin packet arbiter sharing one output FIFO between replacer lanes.
// Valid/ready: a lane may write only while its lane_afull is low, plus DRAIN cycles of slack.
module extend_lane_arbiter #(
    parameter int LANES = 4,
    parameter int DW    = replacer_pkg::DEF_DW,
    parameter int DRAIN = 2
) (
    input  logic                     clk,
    input  logic                     clk_en,
    input  logic                     rst,
    input  logic [LANES-1:0]         lane_req,
    input  logic [LANES*DW-1:0]      lane_data,
    input  logic [LANES-1:0]         lane_wr,
    input  logic [LANES-1:0]         lane_last,
    output logic [LANES-1:0]         lane_afull,
    input  logic                     out_afull,
    output logic [DW-1:0]            data_out,
    output logic                     data_wr,
    output logic                     last_out,
    output logic [$clog2(LANES)-1:0] grant_id,
    output logic                     err,
    output logic [1:0]               state
);

    localparam int GW = $clog2(LANES);

    replacer_pkg::arb_state_t st;
    logic [2:0]                       drain_cnt;
    logic [replacer_pkg::MAX_LANES-1:0] req_ext;
    logic [2:0]                       last_ext;
    logic [2:0]                       next_id;
    logic [LANES-1:0]                 own;
    logic                             active;
    logic                             g_wr;
    logic                             g_last;
    logic [DW-1:0]                    g_data;
    logic                             stray;
    logic                             bad_last;
    logic                             accept;

    assign state = st;

    always_comb begin
        req_ext                = '0;
        req_ext[LANES-1:0]     = lane_req;
        last_ext               = '0;
        last_ext[GW-1:0]       = grant_id;
        next_id                = replacer_pkg::rr_next(req_ext, last_ext, LANES);
    end

    always_comb begin
        own           = '0;
        own[grant_id] = 1'b1;
        active        = (st == replacer_pkg::GRANT) || (st == replacer_pkg::DRAIN);
        g_wr          = lane_wr[grant_id];
        g_last        = lane_last[grant_id];
        g_data        = lane_data[grant_id*DW +: DW];
        // Outside a grant every write is stray; inside, only the owner may write.
        stray         = active ? |(lane_wr & ~own) : |lane_wr;
        bad_last      = (st == replacer_pkg::DRAIN) && g_wr && g_last;
        accept        = active && g_wr && !bad_last;
    end

    always_comb begin
        lane_afull = '1;
        if (st == replacer_pkg::GRANT) lane_afull[grant_id] = out_afull;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= replacer_pkg::IDLE;
            grant_id  <= GW'(LANES - 1);
            drain_cnt <= '0;
            data_out  <= '0;
            data_wr   <= 1'b0;
            last_out  <= 1'b0;
            err       <= 1'b0;
        end else if (!clk_en) begin
            data_wr  <= 1'b0;
            last_out <= 1'b0;
        end else begin
            data_wr  <= 1'b0;
            last_out <= 1'b0;
            if (accept) begin
                data_out <= g_data;
                data_wr  <= 1'b1;
                last_out <= g_last;
            end
            if (stray || bad_last) err <= 1'b1;

            case (st)
                replacer_pkg::IDLE: begin
                    if (|lane_req) begin
                        grant_id <= next_id[GW-1:0];
                        st       <= replacer_pkg::GRANT;
                    end
                end
                replacer_pkg::GRANT: begin
                    if (g_wr && g_last) begin
                        drain_cnt <= 3'(DRAIN);
                        st        <= replacer_pkg::DRAIN;
                    end
                end
                replacer_pkg::DRAIN: begin
                    if (drain_cnt == 3'd1) st <= replacer_pkg::IDLE;
                    else drain_cnt <= drain_cnt - 3'd1;
                end
                default: st <= replacer_pkg::IDLE;
            endcase
        end
    end

endmodule
